// File: rtl/fir_stream_if.sv
// AXI-Stream pair (sample in, filtered sample out) for the FIR stream core.
// The slave modport is the core's view; the master modport is the environment's view.
interface fir_stream_if #(
  parameter int pDATA_WIDTH = 32
);
  logic                   ss_tvalid;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   ss_tlast;
  logic                   ss_tready;
  logic                   sm_tvalid;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic                   sm_tlast;
  logic                   sm_tready;

  modport slave (
    input  ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    output ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );

  modport master (
    output ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    input  ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );
endinterface

// File: rtl/fir_stream_core.sv
// Streaming 11-tap FIR: one sample in, 11 serial MACs over tap/data SRAMs,
// one sample out. Data SRAM is a circular history indexed by ptr.
module fir_stream_core #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ap_start,
  fir_stream_if.slave            axis,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   data_EN,
  output logic [3:0]             data_WE,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  input  logic [pDATA_WIDTH-1:0] data_Do,
  output logic                   ap_idle,
  output logic                   ap_done
);
  localparam int CW = $clog2(Tape_Num + 1);
  localparam int PW = 2 * pDATA_WIDTH;

  typedef enum logic [2:0] {IDLE, INIT, WAIT_IN, MAC, OUT, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt, ptr, rd;
  logic [pDATA_WIDTH-1:0] acc;
  logic                   last_q;
  logic                   dat_en_q;
  logic [3:0]             dat_we_q;
  logic [pADDR_WIDTH-1:0] dat_a_q;

  logic [CW-1:0]          rd_dec, ptr_inc;
  logic signed [PW-1:0]   prod;
  logic [pDATA_WIDTH-1:0] acc_nxt;

  function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [CW-1:0] k);
    return pADDR_WIDTH'(k) << 2;
  endfunction

  assign rd_dec  = (rd == '0) ? CW'(Tape_Num - 1) : rd - CW'(1);
  assign ptr_inc = (ptr == CW'(Tape_Num - 1)) ? '0 : ptr + CW'(1);
  // Full-width signed product; the running sum wraps in pDATA_WIDTH bits.
  assign prod    = PW'($signed(tap_Do)) * PW'($signed(data_Do));
  assign acc_nxt = pDATA_WIDTH'(prod + PW'($signed(acc)));

  // The incoming sample is written in its own handshake cycle so MAC cycle 0
  // can already read it back; everywhere else the SRAM port is registered.
  always_comb begin
    data_EN = dat_en_q;
    data_WE = dat_we_q;
    data_A  = dat_a_q;
    data_Di = '0;
    if (state == WAIT_IN) begin
      data_EN = axis.ss_tvalid;
      data_WE = {4{axis.ss_tvalid}};
      data_A  = word_addr(ptr);
      data_Di = axis.ss_tdata;
    end
  end

  // Control FSM with registered outputs: each transition sets up the next state's outputs.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      ptr            <= '0;
      rd             <= '0;
      acc            <= '0;
      last_q         <= 1'b0;
      ap_idle        <= 1'b1;
      ap_done        <= 1'b0;
      axis.ss_tready <= 1'b0;
      axis.sm_tvalid <= 1'b0;
      axis.sm_tdata  <= '0;
      axis.sm_tlast  <= 1'b0;
      tap_EN         <= 1'b0;
      tap_A          <= '0;
      dat_en_q       <= 1'b0;
      dat_we_q       <= '0;
      dat_a_q        <= '0;
    end else begin
      case (state)
        IDLE: if (ap_start) begin
          state    <= INIT;
          ap_idle  <= 1'b0;
          cnt      <= '0;
          dat_en_q <= 1'b1;
          dat_we_q <= 4'hF;
          dat_a_q  <= word_addr('0);
        end
        INIT: if (cnt == CW'(Tape_Num - 1)) begin
          state          <= WAIT_IN;
          ptr            <= '0;
          dat_en_q       <= 1'b0;
          dat_we_q       <= '0;
          dat_a_q        <= '0;
          axis.ss_tready <= 1'b1;
        end else begin
          cnt     <= cnt + CW'(1);
          dat_a_q <= word_addr(cnt + CW'(1));
        end
        WAIT_IN: if (axis.ss_tvalid && axis.ss_tready) begin
          state          <= MAC;
          axis.ss_tready <= 1'b0;
          last_q         <= axis.ss_tlast;
          acc            <= '0;
          cnt            <= '0;
          rd             <= ptr;
          tap_EN         <= 1'b1;
          tap_A          <= word_addr('0);
          dat_en_q       <= 1'b1;
          dat_we_q       <= '0;
          dat_a_q        <= word_addr(ptr);
        end
        MAC: begin
          // Reads issued at cycle k return at k+1, so cycle 0 has nothing to add.
          if (cnt != '0) acc <= acc_nxt;
          if (cnt < CW'(Tape_Num - 1)) begin
            tap_A   <= word_addr(cnt + CW'(1));
            dat_a_q <= word_addr(rd_dec);
            rd      <= rd_dec;
          end else begin
            tap_EN   <= 1'b0;
            tap_A    <= '0;
            dat_en_q <= 1'b0;
            dat_a_q  <= '0;
          end
          if (cnt == CW'(Tape_Num)) begin
            state          <= OUT;
            axis.sm_tvalid <= 1'b1;
            axis.sm_tdata  <= acc_nxt;
            axis.sm_tlast  <= last_q;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        OUT: if (axis.sm_tready) begin
          axis.sm_tvalid <= 1'b0;
          axis.sm_tlast  <= 1'b0;
          ptr            <= ptr_inc;
          if (last_q) begin
            state   <= DONE;
            ap_done <= 1'b1;
          end else begin
            state          <= WAIT_IN;
            axis.ss_tready <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          ap_done <= 1'b0;
          ap_idle <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_stream_core.sv
// Directed bench for fir_stream_core with behavioural tap/data SRAMs.
module tb_fir_stream_core;
  logic        axis_clk   = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic        ap_start   = 1'b0;
  logic        tap_EN;
  logic [11:0] tap_A;
  logic [31:0] tap_Do;
  logic        data_EN;
  logic [3:0]  data_WE;
  logic [11:0] data_A;
  logic [31:0] data_Di;
  logic [31:0] data_Do;
  logic        ap_idle;
  logic        ap_done;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int acc_cnt = 0;

  logic [31:0] tap_mem [0:1023];
  logic [31:0] dat_mem [0:1023];
  logic [98:0] rst_exp;

  fir_stream_if s_if ();

  fir_stream_core dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .ap_start   (ap_start),
    .axis       (s_if),
    .tap_EN     (tap_EN),
    .tap_A      (tap_A),
    .tap_Do     (tap_Do),
    .data_EN    (data_EN),
    .data_WE    (data_WE),
    .data_A     (data_A),
    .data_Di    (data_Di),
    .data_Do    (data_Do),
    .ap_idle    (ap_idle),
    .ap_done    (ap_done)
  );

  always #5 axis_clk = ~axis_clk;

  // Tap SRAM: synchronous read, 1-cycle latency.
  always @(posedge axis_clk) if (tap_EN) tap_Do <= tap_mem[tap_A[11:2]];

  // Data SRAM: read-first, byte write enables.
  always @(posedge axis_clk) begin
    if (data_EN) begin
      data_Do <= dat_mem[data_A[11:2]];
      for (int b = 0; b < 4; b++)
        if (data_WE[b]) dat_mem[data_A[11:2]][8*b +: 8] <= data_Di[8*b +: 8];
    end
  end

  // Access counters for full-word writes and any SRAM activity.
  always @(posedge axis_clk) begin
    if (data_EN && data_WE == 4'hF) wr_cnt++;
    if (tap_EN || data_EN) acc_cnt++;
  end

  function automatic logic [98:0] outs();
    return {ap_idle, s_if.ss_tready, s_if.sm_tvalid, s_if.sm_tdata, s_if.sm_tlast, ap_done,
            tap_EN, tap_A, data_EN, data_WE, data_A, data_Di};
  endfunction

  task automatic set_taps(input logic [31:0] h [11]);
    for (int i = 0; i < 11; i++) tap_mem[i] = h[i];
  endtask

  task automatic start_frame();
    ap_start = 1'b1;
    @(negedge axis_clk);
    ap_start = 1'b0;
  endtask

  // Push one sample, then take the resulting output with no stall.
  task automatic send_recv(input logic [31:0] x, input logic last,
                           output logic [31:0] y, output logic yl, output logic ok);
    int t = 0;
    ok = 1'b1;
    s_if.ss_tvalid = 1'b1;
    s_if.ss_tdata  = x;
    s_if.ss_tlast  = last;
    while (s_if.ss_tready !== 1'b1 && t < 100) begin @(negedge axis_clk); t++; end
    if (t >= 100) ok = 1'b0;
    @(negedge axis_clk);
    s_if.ss_tvalid = 1'b0;
    s_if.ss_tlast  = 1'b0;
    t = 0;
    while (s_if.sm_tvalid !== 1'b1 && t < 100) begin @(negedge axis_clk); t++; end
    if (t >= 100) ok = 1'b0;
    y  = s_if.sm_tdata;
    yl = s_if.sm_tlast;
    s_if.sm_tready = 1'b1;
    @(negedge axis_clk);
    s_if.sm_tready = 1'b0;
  endtask

  task automatic test_reset();
    int a0;
    axis_rst_n = 1'b0;
    repeat (3) @(negedge axis_clk);
    checks++;
    if (outs() !== rst_exp) begin
      errors++; $display("FAIL reset_outputs got=%h want=%h", outs(), rst_exp);
    end
    checks++;
    if ({dut.ptr, dut.acc, dut.last_q} !== 37'd0) begin
      errors++; $display("FAIL reset_state got=%h want=0", {dut.ptr, dut.acc, dut.last_q});
    end
    axis_rst_n = 1'b1;
    a0 = acc_cnt;
    repeat (10) @(negedge axis_clk);
    checks++;
    if (outs() !== rst_exp) begin
      errors++; $display("FAIL idle_outputs got=%h want=%h", outs(), rst_exp);
    end
    checks++;
    if (acc_cnt - a0 !== 0) begin
      errors++; $display("FAIL idle_no_sram got=%0d want=0", acc_cnt - a0);
    end
  endtask

  task automatic test_impulse();
    logic [31:0] h [11];
    logic [31:0] y, ey;
    logic yl, ok;
    int w0, t;
    for (int i = 0; i < 11; i++) h[i] = 32'(i + 1);
    set_taps(h);
    w0 = wr_cnt;
    start_frame();
    checks++;
    if (ap_idle !== 1'b0) begin
      errors++; $display("FAIL ap_idle_fall got=%b want=0", ap_idle);
    end
    t = 0;
    while (s_if.ss_tready !== 1'b1 && t < 100) begin @(negedge axis_clk); t++; end
    checks++;
    if (wr_cnt - w0 !== 11) begin
      errors++; $display("FAIL init_writes got=%0d want=11", wr_cnt - w0);
    end
    for (int i = 0; i < 12; i++) begin
      send_recv((i == 0) ? 32'd1 : 32'd0, i == 11, y, yl, ok);
      ey = (i <= 10) ? 32'(i + 1) : 32'd0;
      checks++;
      if (ok !== 1'b1 || {yl, y} !== {(i == 11), ey}) begin
        errors++; $display("FAIL impulse[%0d] got=%b/%0d want=%b/%0d ok=%b", i, yl, y, i == 11, ey, ok);
      end
    end
    checks++;
    if (ap_done !== 1'b1) begin
      errors++; $display("FAIL impulse_done got=%b want=1", ap_done);
    end
    @(negedge axis_clk);
    checks++;
    if ({ap_done, ap_idle} !== 2'b01) begin
      errors++; $display("FAIL impulse_idle got=%b want=01", {ap_done, ap_idle});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h [11];
    logic [31:0] y, ey;
    logic yl, ok;
    for (int i = 0; i < 11; i++) h[i] = 32'd1;
    set_taps(h);
    start_frame();
    for (int i = 0; i < 14; i++) begin
      if (i == 5) begin
        start_frame();
        checks++;
        if (ap_idle !== 1'b0) begin
          errors++; $display("FAIL start_ignored got=%b want=0", ap_idle);
        end
      end
      send_recv(32'd2, i == 13, y, yl, ok);
      ey = 32'(2 * ((i + 1 < 11) ? i + 1 : 11));
      checks++;
      if (ok !== 1'b1 || {yl, y} !== {(i == 13), ey}) begin
        errors++; $display("FAIL wrap[%0d] got=%b/%0d want=%b/%0d ok=%b", i, yl, y, i == 13, ey, ok);
      end
    end
    checks++;
    if (ap_done !== 1'b1) begin
      errors++; $display("FAIL wrap_done got=%b want=1", ap_done);
    end
    @(negedge axis_clk);
  endtask

  task automatic test_signed();
    logic [31:0] h [11];
    logic [31:0] y;
    logic [31:0] ev [3];
    logic yl, ok;
    int extra;
    for (int i = 0; i < 11; i++) h[i] = 32'd0;
    h[0] = 32'hFFFF_FFFF;
    set_taps(h);
    start_frame();
    send_recv(32'd3, 1'b1, y, yl, ok);
    checks++;
    if (ok !== 1'b1 || {yl, y} !== {1'b1, 32'hFFFF_FFFD}) begin
      errors++; $display("FAIL signed_neg got=%b/%h want=1/fffffffd ok=%b", yl, y, ok);
    end
    checks++;
    if (ap_done !== 1'b1) begin
      errors++; $display("FAIL single_done got=%b want=1", ap_done);
    end
    extra = 0;
    repeat (5) begin @(negedge axis_clk); if (s_if.sm_tvalid !== 1'b0 || ap_idle !== 1'b1) extra++; end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL single_one_output got=%0d want=0", extra);
    end
    for (int i = 0; i < 11; i++) h[i] = 32'h7FFF_FFFF;
    set_taps(h);
    ev[0] = 32'hFFFF_FFFE; ev[1] = 32'hFFFF_FFFC; ev[2] = 32'hFFFF_FFFA;
    start_frame();
    for (int i = 0; i < 3; i++) begin
      send_recv(32'd2, i == 2, y, yl, ok);
      checks++;
      if (ok !== 1'b1 || y !== ev[i]) begin
        errors++; $display("FAIL overflow[%0d] got=%h want=%h ok=%b", i, y, ev[i], ok);
      end
    end
    @(negedge axis_clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] h [11];
    logic [31:0] y, d0;
    logic yl, ok, l0;
    int t, bad;
    for (int i = 0; i < 11; i++) h[i] = 32'(i + 1);
    set_taps(h);
    start_frame();
    send_recv(32'd5, 1'b0, y, yl, ok);
    checks++;
    if (ok !== 1'b1 || y !== 32'd5) begin
      errors++; $display("FAIL bp_first got=%0d want=5 ok=%b", y, ok);
    end
    s_if.ss_tvalid = 1'b1; s_if.ss_tdata = 32'd7; s_if.ss_tlast = 1'b0;
    t = 0;
    while (s_if.ss_tready !== 1'b1 && t < 100) begin @(negedge axis_clk); t++; end
    @(negedge axis_clk);
    s_if.ss_tvalid = 1'b0;
    t = 0;
    while (s_if.sm_tvalid !== 1'b1 && t < 100) begin @(negedge axis_clk); t++; end
    d0 = s_if.sm_tdata;
    l0 = s_if.sm_tlast;
    s_if.ss_tvalid = 1'b1; s_if.ss_tdata = 32'd9; s_if.ss_tlast = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge axis_clk);
      if (s_if.sm_tdata !== d0 || s_if.sm_tlast !== l0 || s_if.sm_tvalid !== 1'b1 ||
          s_if.ss_tready !== 1'b0) bad++;
    end
    checks++;
    if ({l0, d0} !== {1'b0, 32'd17}) begin
      errors++; $display("FAIL bp_second got=%b/%0d want=0/17", l0, d0);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL bp_stall_stable got=%0d bad cycles want=0", bad);
    end
    s_if.sm_tready = 1'b1;
    @(negedge axis_clk);
    s_if.sm_tready = 1'b0;
    send_recv(32'd9, 1'b1, y, yl, ok);
    checks++;
    if (ok !== 1'b1 || {yl, y} !== {1'b1, 32'd38}) begin
      errors++; $display("FAIL bp_third got=%b/%0d want=1/38 ok=%b", yl, y, ok);
    end
    @(negedge axis_clk);
  endtask

  task automatic test_reset_mid_mac();
    logic [31:0] h [11];
    logic [31:0] y;
    logic yl, ok;
    int t;
    for (int i = 0; i < 11; i++) h[i] = 32'(i + 1);
    set_taps(h);
    start_frame();
    send_recv(32'd4, 1'b0, y, yl, ok);
    send_recv(32'd6, 1'b0, y, yl, ok);
    checks++;
    if (ok !== 1'b1 || y !== 32'd14) begin
      errors++; $display("FAIL pre_reset got=%0d want=14 ok=%b", y, ok);
    end
    s_if.ss_tvalid = 1'b1; s_if.ss_tdata = 32'd100; s_if.ss_tlast = 1'b0;
    t = 0;
    while (s_if.ss_tready !== 1'b1 && t < 100) begin @(negedge axis_clk); t++; end
    @(negedge axis_clk);
    s_if.ss_tvalid = 1'b0;
    repeat (5) @(negedge axis_clk);
    checks++;
    if (tap_EN !== 1'b1) begin
      errors++; $display("FAIL mid_mac_active got=%b want=1", tap_EN);
    end
    axis_rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== rst_exp) begin
      errors++; $display("FAIL mid_mac_reset got=%h want=%h", outs(), rst_exp);
    end
    checks++;
    if ({dut.ptr, dut.acc, dut.last_q} !== 37'd0) begin
      errors++; $display("FAIL mid_mac_state got=%h want=0", {dut.ptr, dut.acc, dut.last_q});
    end
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);
    start_frame();
    for (int i = 0; i < 3; i++) begin
      send_recv((i == 0) ? 32'd1 : 32'd0, i == 2, y, yl, ok);
      checks++;
      if (ok !== 1'b1 || {yl, y} !== {(i == 2), 32'(i + 1)}) begin
        errors++; $display("FAIL after_reset[%0d] got=%b/%0d want=%b/%0d ok=%b", i, yl, y, i == 2, i + 1, ok);
      end
    end
    checks++;
    if (ap_done !== 1'b1) begin
      errors++; $display("FAIL after_reset_done got=%b want=1", ap_done);
    end
    @(negedge axis_clk);
  endtask

  initial begin
    rst_exp = {1'b1, 98'd0};
    s_if.ss_tvalid = 1'b0;
    s_if.ss_tdata  = '0;
    s_if.ss_tlast  = 1'b0;
    s_if.sm_tready = 1'b0;
    for (int i = 0; i < 1024; i++) tap_mem[i] = '0;
    test_reset();
    test_impulse();
    test_back_to_back();
    test_signed();
    test_backpressure();
    test_reset_mid_mac();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
